// File: rtl/bp_table_arbiter.sv
// bp_fifo: small generic FIFO that holds pending branch-predictor updates.
// Latency: an entry pushed at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: push is ignored when full and pop is ignored when empty; the parent gates both.
//
// Ports: clk/rst (async active-high), push_i/push_dat_i write side,
//        pop_i/head_dat_o read side, count_o/full_o/empty_o occupancy status.
module bp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_dat_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];
   assign push_ok    = push_i & ~full_o;
   assign pop_ok     = pop_i & ~empty_o;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_dat_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: it is only observed through a non-empty count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// bp_table_arbiter: init sweep, then lookup/update arbitration of the single predictor table port.
// Latency: lookup granted in the same cycle; queued update written at the earliest the cycle after its push.
// Backpressure: upd_ready_o drops when the update FIFO is full; lookups are refused in INIT/DRAIN or when full.
//
// Ports: clk/rst (async active-high); lookup_req_i/lookup_pc_i -> lookup_grant_o (fetch side);
//        upd_valid_i/upd_pc_i/upd_taken_i/upd_target_i -> upd_ready_o (EX side); flush_i drain request;
//        tbl_* table port strobes and write data; busy_o (INIT or DRAIN); fifo_count_o occupancy.
module bp_table_arbiter #(
   parameter int INDEX_W = 10,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lookup_req_i,
   input  logic [31:0]              lookup_pc_i,
   output logic                     lookup_grant_o,
   input  logic                     upd_valid_i,
   input  logic [31:0]              upd_pc_i,
   input  logic                     upd_taken_i,
   input  logic [31:0]              upd_target_i,
   output logic                     upd_ready_o,
   input  logic                     flush_i,
   output logic                     tbl_rd_en_o,
   output logic                     tbl_wr_en_o,
   output logic                     tbl_init_o,
   output logic [INDEX_W-1:0]       tbl_index_o,
   output logic [31:0]              tbl_wr_pc_o,
   output logic                     tbl_wr_taken_o,
   output logic [31:0]              tbl_wr_target_o,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } upd_t;

   state_t             state_q, state_d;
   logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;

   upd_t               push_dat;
   upd_t               head_dat;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   count_nxt;
   logic               upd_grant;
   logic               unused_lookup_pc;

   assign unused_lookup_pc = ^{lookup_pc_i[31:INDEX_W+2], lookup_pc_i[1:0]};

   assign push_dat     = '{pc: upd_pc_i, taken: upd_taken_i, target: upd_target_i};
   assign upd_ready_o  = ~fifo_full;
   assign push         = upd_valid_i & upd_ready_o;
   assign fifo_count_o = fifo_count;
   assign busy_o       = (state_q != ST_RUN);

   bp_fifo #(
      .WIDTH ($bits(upd_t)),
      .DEPTH (DEPTH)
   ) u_upd_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_comb begin
      state_d         = state_q;
      init_cnt_d      = init_cnt_q;
      upd_grant       = 1'b0;
      lookup_grant_o  = 1'b0;
      tbl_rd_en_o     = 1'b0;
      tbl_wr_en_o     = 1'b0;
      tbl_init_o      = 1'b0;
      tbl_index_o     = '0;
      tbl_wr_pc_o     = '0;
      tbl_wr_taken_o  = 1'b0;
      tbl_wr_target_o = '0;

      unique case (state_q)
         ST_INIT: begin
            tbl_wr_en_o = 1'b1;
            tbl_init_o  = 1'b1;
            tbl_index_o = init_cnt_q;
            init_cnt_d  = init_cnt_q + 1'b1;
            if (&init_cnt_q) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A full FIFO forces the head write so lookups cannot starve updates.
            if (fifo_full || (!lookup_req_i && !fifo_empty)) begin
               upd_grant = 1'b1;
            end else if (lookup_req_i) begin
               lookup_grant_o = 1'b1;
               tbl_rd_en_o    = 1'b1;
               tbl_index_o    = lookup_pc_i[INDEX_W+1:2];
            end
            if (flush_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            upd_grant = !fifo_empty;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      if (upd_grant) begin
         tbl_wr_en_o     = 1'b1;
         tbl_index_o     = head_dat.pc[INDEX_W+1:2];
         tbl_wr_pc_o     = head_dat.pc;
         tbl_wr_taken_o  = head_dat.taken;
         tbl_wr_target_o = head_dat.target;
      end
      pop = upd_grant;

      // Leave DRAIN once the FIFO will be empty after this edge; a push
      // arriving during the drain keeps us draining.
      count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
      if ((state_q == ST_DRAIN) && (count_nxt == '0)) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end
endmodule

// File: tb/tb_bp_table_arbiter.sv
// Bench for bp_table_arbiter with INDEX_W=4, DEPTH=4: table of per-cycle vectors
// plus reset/init sequences; a queue of expected updates models the FIFO contents.
module tb_bp_table_arbiter;
   localparam int INDEX_W = 4;
   localparam int DEPTH   = 4;
   localparam int NIDX    = 1 << INDEX_W;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    lookup_req_i = 1'b0;
   logic [31:0]             lookup_pc_i = '0;
   logic                    lookup_grant_o;
   logic                    upd_valid_i = 1'b0;
   logic [31:0]             upd_pc_i = '0;
   logic                    upd_taken_i = 1'b0;
   logic [31:0]             upd_target_i = '0;
   logic                    upd_ready_o;
   logic                    flush_i = 1'b0;
   logic                    tbl_rd_en_o;
   logic                    tbl_wr_en_o;
   logic                    tbl_init_o;
   logic [INDEX_W-1:0]      tbl_index_o;
   logic [31:0]             tbl_wr_pc_o;
   logic                    tbl_wr_taken_o;
   logic [31:0]             tbl_wr_target_o;
   logic                    busy_o;
   logic [$clog2(DEPTH):0]  fifo_count_o;

   bp_table_arbiter #(.INDEX_W(INDEX_W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .lookup_req_i    (lookup_req_i),
      .lookup_pc_i     (lookup_pc_i),
      .lookup_grant_o  (lookup_grant_o),
      .upd_valid_i     (upd_valid_i),
      .upd_pc_i        (upd_pc_i),
      .upd_taken_i     (upd_taken_i),
      .upd_target_i    (upd_target_i),
      .upd_ready_o     (upd_ready_o),
      .flush_i         (flush_i),
      .tbl_rd_en_o     (tbl_rd_en_o),
      .tbl_wr_en_o     (tbl_wr_en_o),
      .tbl_init_o      (tbl_init_o),
      .tbl_index_o     (tbl_index_o),
      .tbl_wr_pc_o     (tbl_wr_pc_o),
      .tbl_wr_taken_o  (tbl_wr_taken_o),
      .tbl_wr_target_o (tbl_wr_target_o),
      .busy_o          (busy_o),
      .fifo_count_o    (fifo_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        utk;
      logic [31:0] utg;
      logic        fl;
      logic        e_grant;
      logic        e_wr;
      logic        e_busy;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } upd_t;

   upd_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic req, input logic [31:0] lpc, input logic uv,
                               input logic [31:0] upc, input logic utk, input logic [31:0] utg,
                               input logic fl, input logic eg, input logic ew, input logic eb);
      vec_t v;
      v.req = req; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utk = utk; v.utg = utg;
      v.fl = fl; v.e_grant = eg; v.e_wr = ew; v.e_busy = eb;
      return v;
   endfunction

   // One RUN/DRAIN cycle: starts 1 time unit after a rising edge, ends likewise.
   task automatic cycle(input vec_t v, input string tag);
      int   sz;
      logic accept;
      upd_t u;
      lookup_req_i = v.req; lookup_pc_i = v.lpc;
      upd_valid_i = v.uv; upd_pc_i = v.upc; upd_taken_i = v.utk; upd_target_i = v.utg;
      flush_i = v.fl;
      #1;
      sz = sb.size();
      chk({tag, " grant"}, 64'(lookup_grant_o), 64'(v.e_grant));
      chk({tag, " rd_en"}, 64'(tbl_rd_en_o), 64'(v.e_grant));
      chk({tag, " wr_en"}, 64'(tbl_wr_en_o), 64'(v.e_wr));
      chk({tag, " init"}, 64'(tbl_init_o), 64'(0));
      chk({tag, " busy"}, 64'(busy_o), 64'(v.e_busy));
      chk({tag, " ready"}, 64'(upd_ready_o), 64'(sz < DEPTH));
      chk({tag, " count"}, 64'(fifo_count_o), 64'(sz));
      if (v.e_grant) begin
         chk({tag, " lookup index"}, 64'(tbl_index_o), 64'(v.lpc[INDEX_W+1:2]));
      end else if (v.e_wr) begin
         if (sz == 0) begin
            chk({tag, " scoreboard has entry"}, 64'(0), 64'(1));
         end else begin
            u = sb[0];
            chk({tag, " wr index"}, 64'(tbl_index_o), 64'(u.pc[INDEX_W+1:2]));
            chk({tag, " wr pc"}, 64'(tbl_wr_pc_o), 64'(u.pc));
            chk({tag, " wr taken"}, 64'(tbl_wr_taken_o), 64'(u.taken));
            chk({tag, " wr target"}, 64'(tbl_wr_target_o), 64'(u.target));
         end
      end else begin
         chk({tag, " idle index"}, 64'(tbl_index_o), 64'(0));
      end
      accept = v.uv && (sz < DEPTH);
      @(posedge clk);
      if (v.e_wr && sz != 0) void'(sb.pop_front());
      if (accept) sb.push_back('{v.upc, v.utk, v.utg});
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      lookup_req_i = 1'b1; upd_valid_i = 1'b0; flush_i = 1'b0;
      sb.delete();
      #1;
      chk("rst busy", 64'(busy_o), 64'(1));
      chk("rst wr_en", 64'(tbl_wr_en_o), 64'(1));
      chk("rst init", 64'(tbl_init_o), 64'(1));
      chk("rst index", 64'(tbl_index_o), 64'(0));
      chk("rst grant", 64'(lookup_grant_o), 64'(0));
      chk("rst rd_en", 64'(tbl_rd_en_o), 64'(0));
      chk("rst ready", 64'(upd_ready_o), 64'(1));
      chk("rst count", 64'(fifo_count_o), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Init sweep; optionally pushes one update at push_at and stops (before the edge) at stop_at.
   task automatic sweep(input int stop_at, input int push_at);
      for (int i = 0; i < NIDX; i++) begin
         lookup_req_i = 1'b1; lookup_pc_i = 32'h0000_0ffc; flush_i = (i == 2);
         upd_valid_i = (i == push_at);
         upd_pc_i = 32'h0000_0044; upd_taken_i = 1'b1; upd_target_i = 32'h0000_0bad;
         #1;
         chk($sformatf("init%0d wr_en", i), 64'(tbl_wr_en_o), 64'(1));
         chk($sformatf("init%0d init", i), 64'(tbl_init_o), 64'(1));
         chk($sformatf("init%0d index", i), 64'(tbl_index_o), 64'(i));
         chk($sformatf("init%0d busy", i), 64'(busy_o), 64'(1));
         chk($sformatf("init%0d grant", i), 64'(lookup_grant_o), 64'(0));
         chk($sformatf("init%0d wr_pc", i), 64'(tbl_wr_pc_o), 64'(0));
         chk($sformatf("init%0d count", i), 64'(fifo_count_o), 64'(sb.size()));
         if (i == stop_at) return;
         @(posedge clk);
         if (i == push_at) sb.push_back('{upd_pc_i, upd_taken_i, upd_target_i});
         #1;
      end
      upd_valid_i = 1'b0; flush_i = 1'b0;
   endtask

   vec_t vecs[23];

   initial begin
      // RUN: single update with no lookups, then index 4 write
      vecs[0]  = mk(T, 32'h0000_0100, F, 32'h0, F, 32'h0, F, T, F, F);
      vecs[1]  = mk(F, 32'h0, T, 32'h0000_0010, T, 32'h0000_0040, F, F, F, F);
      vecs[2]  = mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, T, F);
      vecs[3]  = mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, F, F);
      // Lookups held; fill to 4, forced write, refused push
      vecs[4]  = mk(T, 32'h0000_0204, T, 32'h0000_0020, F, 32'h0000_1000, F, T, F, F);
      vecs[5]  = mk(T, 32'h0000_0208, T, 32'h0000_0024, T, 32'h0000_2000, F, T, F, F);
      vecs[6]  = mk(T, 32'h0000_020c, T, 32'h0000_003c, F, 32'h0000_3000, F, T, F, F);
      vecs[7]  = mk(T, 32'h0000_0210, T, 32'h0000_0028, T, 32'h0000_4000, F, T, F, F);
      vecs[8]  = mk(T, 32'h0000_0214, T, 32'h0000_002c, T, 32'h0000_5000, F, F, T, F);
      vecs[9]  = mk(T, 32'h0000_0218, F, 32'h0, F, 32'h0, F, T, F, F);
      // Flush with 3 queued, lookups held
      vecs[10] = mk(T, 32'h0000_021c, F, 32'h0, F, 32'h0, T, T, F, F);
      vecs[11] = mk(T, 32'h0000_0220, F, 32'h0, F, 32'h0, F, F, T, T);
      vecs[12] = mk(T, 32'h0000_0224, F, 32'h0, F, 32'h0, F, F, T, T);
      vecs[13] = mk(T, 32'h0000_0228, F, 32'h0, F, 32'h0, F, F, T, T);
      vecs[14] = mk(T, 32'h0000_022c, F, 32'h0, F, 32'h0, F, T, F, F);
      // Push and pop together at count 2
      vecs[15] = mk(T, 32'h0000_0230, T, 32'h0000_0030, T, 32'h0000_6000, F, T, F, F);
      vecs[16] = mk(T, 32'h0000_0234, T, 32'h0000_0034, F, 32'h0000_7000, F, T, F, F);
      vecs[17] = mk(F, 32'h0, T, 32'h0000_0038, T, 32'h0000_8000, F, F, T, F);
      vecs[18] = mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, T, F);
      vecs[19] = mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, T, F);
      // Flush with empty FIFO: one DRAIN cycle
      vecs[20] = mk(T, 32'h0000_0238, F, 32'h0, F, 32'h0, T, T, F, F);
      vecs[21] = mk(T, 32'h0000_023c, F, 32'h0, F, 32'h0, F, F, F, T);
      vecs[22] = mk(T, 32'h0000_0240, F, 32'h0, F, 32'h0, F, T, F, F);

      @(posedge clk);
      #1;
      do_reset();
      sweep(-1, -1);
      for (int i = 0; i < 23; i++) cycle(vecs[i], $sformatf("v%0d", i));

      // Reset mid-RUN with two entries queued
      cycle(mk(T, 32'h0000_0300, T, 32'h0000_0050, T, 32'h0000_9000, F, T, F, F), "q0");
      cycle(mk(T, 32'h0000_0304, T, 32'h0000_0054, F, 32'h0000_a000, F, T, F, F), "q1");
      do_reset();
      // Reset mid-INIT at counter 7, with an update pushed during INIT
      sweep(7, 3);
      do_reset();
      sweep(-1, -1);
      cycle(mk(T, 32'h0000_0308, F, 32'h0, F, 32'h0, F, T, F, F), "post0");
      cycle(mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, F, F), "post1");
      cycle(mk(F, 32'h0, F, 32'h0, F, 32'h0, F, F, F, F), "post2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
